// File: rtl/pu_io_initiator_if.sv
//----------------------------------------------------------------------------
// pu_io_initiator_if : PU I/O request/ack bus between initiator and responder
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

package pu_io_initiator_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [7:0]  tag;
    logic [31:0] addr;
  } io_type;
endpackage

interface pu_io_initiator_if #(
  parameter int WIDTH_NBITS = `PU_WIDTH_NBITS
) ();
  logic                         io_req;
  pu_io_initiator_pkg::io_type  io_cmd;
  logic                         io_ack;
  logic [WIDTH_NBITS-1:0]       io_ack_data;

  modport master (
    output io_req,
    output io_cmd,
    input  io_ack,
    input  io_ack_data
  );

  modport slave (
    input  io_req,
    input  io_cmd,
    output io_ack,
    output io_ack_data
  );
endinterface

`default_nettype wire

// File: rtl/pu_io_initiator.sv
//----------------------------------------------------------------------------
// pu_io_initiator : per-PU read initiator with 2-deep request queue,
//                   per-request timeout and stale-ack absorption.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

module pu_io_initiator
  import pu_io_initiator_pkg::*;
#(
  parameter int WIDTH_NBITS   = `PU_WIDTH_NBITS,
  parameter int ADDR_NBITS    = 32,
  parameter int TIMEOUT_NBITS = 10
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_core_rd,
  input  wire logic [ADDR_NBITS-1:0]  i_core_addr,
  output logic                        o_core_rd_rdy,
  output logic                        o_core_ack,
  output logic [WIDTH_NBITS-1:0]      o_core_rdata,
  output logic                        o_core_err,
  pu_io_initiator_if.master           io,
  output logic [15:0]                 o_timeout_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STALE = 2'd2;

  localparam logic [TIMEOUT_NBITS-1:0] C_LIMIT = '1;
  localparam logic [TIMEOUT_NBITS-1:0] C_ONE   = {{(TIMEOUT_NBITS-1){1'b0}}, 1'b1};

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [TIMEOUT_NBITS-1:0] r_timer;

  logic [ADDR_NBITS-1:0]    r_fifo [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;

  logic                     w_push;
  logic                     w_empty;
  logic                     w_timer_hit;
  logic                     w_launch;
  logic                     w_done;
  logic                     w_tmo;

  logic                     r_io_req;
  io_type                   r_io_cmd;
  logic                     r_core_ack;
  logic                     r_core_err;
  logic [WIDTH_NBITS-1:0]   r_core_rdata;
  logic [15:0]              r_timeout_cnt;

  // Ready reflects the count before any same-cycle pop.
  assign o_core_rd_rdy = (r_count != 2'd2);
  assign w_push        = i_core_rd & o_core_rd_rdy;
  assign w_empty       = (r_count == 2'd0);
  assign w_timer_hit   = (r_timer == C_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_core_addr;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_launch) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_launch};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io.io_ack)        w_state_nxt = S_IDLE;
        else if (w_timer_hit) w_state_nxt = S_STALE;
      end
      S_STALE: begin
        // A late ack ends the stale window; a queued read leaves straight away.
        if (io.io_ack)        w_state_nxt = w_empty ? S_IDLE : S_WAIT;
        else if (w_timer_hit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_launch = 1'b0;
    w_done   = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      S_IDLE:  w_launch = !w_empty;
      S_WAIT: begin
        w_done = io.io_ack;
        w_tmo  = !io.io_ack && w_timer_hit;
      end
      S_STALE: w_launch = io.io_ack && !w_empty;
      default: w_launch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer       <= '0;
      r_io_req      <= 1'b0;
      r_io_cmd      <= '0;
      r_core_ack    <= 1'b0;
      r_core_err    <= 1'b0;
      r_core_rdata  <= '0;
      r_timeout_cnt <= 16'd0;
    end else begin
      if (w_launch || w_tmo) begin
        r_timer <= '0;
      end else if (r_state != S_IDLE) begin
        r_timer <= r_timer + C_ONE;
      end

      r_io_req <= w_launch;
      if (w_launch) begin
        r_io_cmd      <= '0;
        r_io_cmd.addr <= r_fifo[r_rd_ptr];
      end

      r_core_ack <= w_done | w_tmo;
      r_core_err <= w_tmo;
      if (w_done) begin
        r_core_rdata <= io.io_ack_data;
      end else if (w_tmo) begin
        r_core_rdata <= '0;
      end

      if (w_tmo && (r_timeout_cnt != 16'hFFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 16'd1;
      end
    end
  end

  assign io.io_req     = r_io_req;
  assign io.io_cmd     = r_io_cmd;
  assign o_core_ack    = r_core_ack;
  assign o_core_err    = r_core_err;
  assign o_core_rdata  = r_core_rdata;
  assign o_timeout_cnt = r_timeout_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pu_io_initiator.sv
//----------------------------------------------------------------------------
// tb_pu_io_initiator : vector table, directed corner cases and a randomized
//                      run against a timestamp-based reference model.
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_pu_io_initiator;

  localparam int LIMIT  = 15;
  localparam int NO_ACK = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rd = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_rd_rdy;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic        core_err;
  logic [15:0] timeout_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pu_io_initiator_if #(.WIDTH_NBITS(32)) io ();

  pu_io_initiator #(
    .WIDTH_NBITS   (32),
    .ADDR_NBITS    (32),
    .TIMEOUT_NBITS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_core_rd     (core_rd),
    .i_core_addr   (core_addr),
    .o_core_rd_rdy (core_rd_rdy),
    .o_core_ack    (core_ack),
    .o_core_rdata  (core_rdata),
    .o_core_err    (core_err),
    .io            (io),
    .o_timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          exp_ack_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [15:0] exp_tcnt;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          req_cyc = -1;
    int          ack_cyc = -1;
    int          nreq = 0;
    int          nack = 0;
    logic [31:0] got_addr = '0;
    logic [31:0] got_data = '0;
    logic        got_err = 1'b0;
    chk($sformatf("v%0d_rdy", idx), core_rd_rdy, 1);
    core_rd   = 1'b1;
    core_addr = v.addr;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) core_rd = 1'b0;
      if (io.io_req === 1'b1) begin
        req_cyc  = c;
        got_addr = io.io_cmd.addr;
        nreq++;
      end
      if (core_ack === 1'b1) begin
        if (nack == 0) begin
          ack_cyc  = c;
          got_data = core_rdata;
          got_err  = core_err;
        end
        nack++;
      end
      io.io_ack      = (req_cyc >= 0) && (v.lat != NO_ACK) && (c == req_cyc + v.lat);
      io.io_ack_data = io.io_ack ? v.data : $urandom;
      tick();
    end
    io.io_ack = 1'b0;
    chk($sformatf("v%0d_req_cyc", idx), req_cyc, 2);
    chk($sformatf("v%0d_req_n", idx), nreq, 1);
    chk($sformatf("v%0d_addr", idx), got_addr, v.addr);
    chk($sformatf("v%0d_ack_cyc", idx), ack_cyc, v.exp_ack_cyc);
    chk($sformatf("v%0d_ack_n", idx), nack, 1);
    chk($sformatf("v%0d_err", idx), got_err, v.exp_err);
    chk($sformatf("v%0d_rdata", idx), got_data, v.exp_rdata);
    chk($sformatf("v%0d_tcnt", idx), timeout_cnt, v.exp_tcnt);
  endtask

  function automatic int pick_lat();
    int r = int'($urandom_range(0, 99));
    if (r < 68) return int'($urandom_range(0, 6));
    if (r < 78) return int'($urandom_range(13, 15));
    if (r < 90) return int'($urandom_range(16, 31));
    return NO_ACK;
  endfunction

  initial begin
    logic [31:0] bp_addr [4];
    logic        bp_rdy  [4];
    int          bp_req_cyc [4];
    logic [31:0] bp_req_addr [4];
    int          bp_nreq;
    int          last_req;
    int          st_ack_cyc [4];
    logic        st_ack_err [4];
    logic [31:0] st_ack_data [4];
    int          st_req_cyc [4];
    logic [31:0] st_req_addr [4];
    int          st_nack;
    int          st_nreq;
    int          rs_cnt;

    // addr, data, responder latency, core_ack cycle, err, rdata, timeout_cnt
    vecs[0] = '{32'h0000_0040, 32'h0000_DEAD, 3,      6,  1'b0, 32'h0000_DEAD, 16'd0};
    vecs[1] = '{32'h0000_1234, 32'hCAFE_F00D, 0,      3,  1'b0, 32'hCAFE_F00D, 16'd0};
    vecs[2] = '{32'h0000_0080, 32'h0000_55AA, 15,     18, 1'b0, 32'h0000_55AA, 16'd0};
    vecs[3] = '{32'h0000_0084, 32'h0000_1111, 14,     17, 1'b0, 32'h0000_1111, 16'd0};
    vecs[4] = '{32'h0000_0088, 32'h0000_2222, NO_ACK, 18, 1'b1, 32'h0,         16'd1};
    vecs[5] = '{32'h0000_008C, 32'h0000_3333, 21,     18, 1'b1, 32'h0,         16'd2};

    io.io_ack      = 1'b0;
    io.io_ack_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_io_req", io.io_req, 0);
    chk("rst_io_cmd", io.io_cmd, 0);
    chk("rst_core_ack", core_ack, 0);
    chk("rst_core_err", core_err, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    chk("rst_rdy", core_rd_rdy, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-pressure: four reads on consecutive cycles, responder latency 4.
    bp_addr = '{32'hA000_0000, 32'hB000_0004, 32'hC000_0008, 32'hD000_000C};
    bp_nreq  = 0;
    last_req = -100;
    for (int c = 0; c < 40; c++) begin
      core_rd   = (c < 4);
      core_addr = (c < 4) ? bp_addr[c] : '0;
      if (c < 4) bp_rdy[c] = core_rd_rdy;
      if (io.io_req === 1'b1) begin
        if (bp_nreq < 4) begin
          bp_req_cyc[bp_nreq]  = c;
          bp_req_addr[bp_nreq] = io.io_cmd.addr;
        end
        bp_nreq++;
        last_req = c;
      end
      io.io_ack      = (c == last_req + 4);
      io.io_ack_data = $urandom;
      tick();
    end
    core_rd   = 1'b0;
    io.io_ack = 1'b0;
    chk("bp_rdy0", bp_rdy[0], 1);
    chk("bp_rdy1", bp_rdy[1], 1);
    chk("bp_rdy2", bp_rdy[2], 1);
    chk("bp_rdy3_full", bp_rdy[3], 0);
    chk("bp_nreq", bp_nreq, 3);
    chk("bp_req0_cyc", bp_req_cyc[0], 2);
    chk("bp_req1_cyc", bp_req_cyc[1], 8);
    chk("bp_req2_cyc", bp_req_cyc[2], 14);
    chk("bp_req0_addr", bp_req_addr[0], bp_addr[0]);
    chk("bp_req1_addr", bp_req_addr[1], bp_addr[1]);
    chk("bp_req2_addr", bp_req_addr[2], bp_addr[2]);

    // Stale ack: X times out (core_ack at 18), late ack at 23, Y queued at 5.
    st_nack = 0;
    st_nreq = 0;
    for (int c = 0; c < 40; c++) begin
      core_rd   = (c == 0) || (c == 5);
      core_addr = (c == 0) ? 32'h0000_0A00 : 32'h0000_0B00;
      if (c == 20) chk("st_cmd_hold", io.io_cmd.addr, 32'h0000_0A00);
      if (io.io_req === 1'b1) begin
        if (st_nreq < 4) begin
          st_req_cyc[st_nreq]  = c;
          st_req_addr[st_nreq] = io.io_cmd.addr;
        end
        st_nreq++;
      end
      if (core_ack === 1'b1) begin
        if (st_nack < 4) begin
          st_ack_cyc[st_nack]  = c;
          st_ack_err[st_nack]  = core_err;
          st_ack_data[st_nack] = core_rdata;
        end
        st_nack++;
      end
      io.io_ack      = (c == 23) || (c == 26);
      io.io_ack_data = (c == 26) ? 32'h0000_BEEF : 32'h0000_0BAD;
      tick();
    end
    core_rd   = 1'b0;
    io.io_ack = 1'b0;
    chk("st_nreq", st_nreq, 2);
    chk("st_req0_cyc", st_req_cyc[0], 2);
    chk("st_req1_cyc", st_req_cyc[1], 24);
    chk("st_req1_addr", st_req_addr[1], 32'h0000_0B00);
    chk("st_nack", st_nack, 2);
    chk("st_ack0_cyc", st_ack_cyc[0], 18);
    chk("st_ack0_err", st_ack_err[0], 1);
    chk("st_ack0_data", st_ack_data[0], 0);
    chk("st_ack1_cyc", st_ack_cyc[1], 27);
    chk("st_ack1_err", st_ack_err[1], 0);
    chk("st_ack1_data", st_ack_data[1], 32'h0000_BEEF);
    chk("st_tcnt", timeout_cnt, 3);

    // Reset while waiting: ack after reset must be ignored.
    rs_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      core_rd   = (c == 0);
      core_addr = 32'h0000_0C00;
      rst       = (c == 4);
      if (c == 2) chk("rs_req_before", io.io_req, 1);
      if (c == 5) begin
        chk("rs_io_req", io.io_req, 0);
        chk("rs_io_cmd", io.io_cmd, 0);
        chk("rs_core_ack", core_ack, 0);
        chk("rs_core_err", core_err, 0);
        chk("rs_core_rdata", core_rdata, 0);
        chk("rs_tcnt", timeout_cnt, 0);
        chk("rs_rdy", core_rd_rdy, 1);
      end
      if (c >= 5 && (core_ack === 1'b1 || io.io_req === 1'b1)) rs_cnt++;
      io.io_ack      = (c == 6);
      io.io_ack_data = 32'h0000_F00D;
      tick();
    end
    core_rd   = 1'b0;
    rst       = 1'b0;
    io.io_ack = 1'b0;
    chk("rs_no_activity", rs_cnt, 0);

    // Randomized run: timestamps of outstanding request, latency and idle time.
    begin
      logic [31:0] mq [$];
      int          t = -1;
      int          lat = 0;
      int          idle_at = 0;
      logic        e_req = 1'b0;
      logic        e_ack = 1'b0;
      logic        e_err = 1'b0;
      logic [31:0] e_data = '0;
      logic [31:0] e_cmd = '0;
      logic [15:0] e_tcnt = '0;
      logic        ack_now;
      logic        rdy_m;
      logic        launch_ok;
      for (int c = 0; c < 3000; c++) begin
        rdy_m = (mq.size() < 2);
        chk("rnd_io_req", io.io_req, e_req);
        chk("rnd_io_cmd", io.io_cmd.addr, e_cmd);
        chk("rnd_core_ack", core_ack, e_ack);
        if (e_ack) begin
          chk("rnd_core_err", core_err, e_err);
          chk("rnd_core_rdata", core_rdata, e_data);
        end
        chk("rnd_tcnt", timeout_cnt, e_tcnt);
        chk("rnd_rdy", core_rd_rdy, rdy_m);

        core_rd        = ($urandom_range(0, 99) < 45);
        core_addr      = $urandom;
        ack_now        = (t >= 0) && (lat != NO_ACK) && (c == t + lat);
        io.io_ack      = ack_now;
        io.io_ack_data = $urandom;

        e_req     = 1'b0;
        e_ack     = 1'b0;
        e_err     = 1'b0;
        launch_ok = 1'b0;
        if (t >= 0) begin
          if (lat <= LIMIT) begin
            if (ack_now) begin
              e_ack   = 1'b1;
              e_data  = io.io_ack_data;
              idle_at = c + 1;
              t       = -1;
            end
          end else begin
            if (c == t + LIMIT) begin
              e_ack  = 1'b1;
              e_err  = 1'b1;
              e_data = '0;
              if (e_tcnt != 16'hFFFF) e_tcnt++;
            end
            if (ack_now) begin
              launch_ok = 1'b1;
              idle_at   = c + 1;
              t         = -1;
            end else if (c == t + 2 * LIMIT + 1) begin
              idle_at = c + 1;
              t       = -1;
            end
          end
        end else if (c >= idle_at) begin
          launch_ok = 1'b1;
        end
        if (launch_ok && mq.size() > 0) begin
          e_req = 1'b1;
          e_cmd = mq.pop_front();
          t     = c + 1;
          lat   = pick_lat();
        end
        if (core_rd && rdy_m) mq.push_back(core_addr);
        tick();
      end
      core_rd   = 1'b0;
      io.io_ack = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
